// File: rtl/cmd_decoder_if.sv
// Handshake between the shared command register and the command decoder.
// The register side presents a byte; the decoder pulses rd once it has consumed it.
interface cmd_decoder_if;
  logic       has_data;
  logic [7:0] rd_data;
  logic       rd;

  modport master (
    output has_data,
    output rd_data,
    input  rd
  );

  modport slave (
    input  has_data,
    input  rd_data,
    output rd
  );
endinterface

// File: rtl/cmd_decoder.sv
// Byte-stream command decoder that drives line-buffer writes and the fg/bg colour registers.
//
//   state    | meaning
//   OPCODE   | waiting for / decoding the first byte of a command
//   ARG_LO   | waiting for / consuming the low argument byte
//   ARG_HI   | waiting for / consuming the high argument byte, then executing
//   FILL     | writing {hi,lo} to all 256 line-buffer words, no byte fetches
module cmd_decoder (
  input  logic                clk,
  input  logic                nrst,
  cmd_decoder_if.slave        bus,
  output logic                lb_wr,
  output logic [7:0]          lb_wr_addr,
  output logic [15:0]         lb_wr_data,
  output logic [11:0]         fg_color,
  output logic [11:0]         bg_color,
  output logic                cmd_err
);

  typedef enum logic [1:0] {
    S_OPCODE = 2'd0,
    S_ARG_LO = 2'd1,
    S_ARG_HI = 2'd2,
    S_FILL   = 2'd3
  } state_t;

  localparam logic [2:0]  OP_SET_ADDR = 3'd1;
  localparam logic [2:0]  OP_WRITE    = 3'd2;
  localparam logic [2:0]  OP_SET_FG   = 3'd3;
  localparam logic [2:0]  OP_SET_BG   = 3'd4;
  localparam logic [2:0]  OP_FILL     = 3'd5;

  localparam logic [11:0] FG_RESET    = 12'hFF0;
  localparam logic [11:0] BG_RESET    = 12'h208;

  state_t      state_q;
  logic        ready_q;
  logic        phase_b_q;
  logic [7:0]  byte_q;
  logic [7:0]  lo_q;
  logic [2:0]  op_q;
  logic        rd_q;
  logic        lb_wr_q;
  logic [7:0]  addr_q;
  logic [15:0] data_q;
  logic [11:0] fg_q;
  logic [11:0] bg_q;
  logic        err_q;
  logic        op_known;

  assign op_known = (byte_q >= 8'd1) && (byte_q <= 8'd5);

  // A byte is latched on one edge (rd goes high) and acted upon on the next,
  // so every byte costs exactly two cycles and rd can never stay high.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= S_OPCODE;
      ready_q   <= 1'b0;
      phase_b_q <= 1'b0;
      byte_q    <= 8'h00;
      lo_q      <= 8'h00;
      op_q      <= 3'd0;
      rd_q      <= 1'b0;
      lb_wr_q   <= 1'b0;
      addr_q    <= 8'h00;
      data_q    <= 16'h0000;
      fg_q      <= FG_RESET;
      bg_q      <= BG_RESET;
      err_q     <= 1'b0;
    end else begin
      rd_q    <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b1;
      if (state_q == S_FILL) begin
        if (addr_q == 8'hFF) begin
          lb_wr_q <= 1'b0;
          addr_q  <= 8'h00;
          state_q <= S_OPCODE;
        end else begin
          addr_q  <= addr_q + 8'd1;
        end
      end else begin
        // Post-increment after a single WRITE_WORD strobe.
        if (lb_wr_q) begin
          lb_wr_q <= 1'b0;
          addr_q  <= addr_q + 8'd1;
        end
        if (phase_b_q) begin
          phase_b_q <= 1'b0;
          case (state_q)
            S_OPCODE: begin
              if (op_known) begin
                op_q    <= byte_q[2:0];
                state_q <= S_ARG_LO;
              end else begin
                err_q   <= 1'b1;
              end
            end
            S_ARG_LO: begin
              lo_q <= byte_q;
              if (op_q == OP_SET_ADDR) begin
                addr_q  <= byte_q;
                state_q <= S_OPCODE;
              end else begin
                state_q <= S_ARG_HI;
              end
            end
            S_ARG_HI: begin
              state_q <= S_OPCODE;
              case (op_q)
                OP_WRITE: begin
                  lb_wr_q <= 1'b1;
                  data_q  <= {byte_q, lo_q};
                end
                OP_SET_FG: fg_q <= {lo_q, byte_q[3:0]};
                OP_SET_BG: bg_q <= {lo_q, byte_q[3:0]};
                OP_FILL: begin
                  lb_wr_q <= 1'b1;
                  addr_q  <= 8'h00;
                  data_q  <= {byte_q, lo_q};
                  state_q <= S_FILL;
                end
                default: ;
              endcase
            end
            default: state_q <= S_OPCODE;
          endcase
        end else if (ready_q && bus.has_data) begin
          byte_q    <= bus.rd_data;
          rd_q      <= 1'b1;
          phase_b_q <= 1'b1;
        end
      end
    end
  end

  assign bus.rd     = rd_q;
  assign lb_wr      = lb_wr_q;
  assign lb_wr_addr = addr_q;
  assign lb_wr_data = data_q;
  assign fg_color   = fg_q;
  assign bg_color   = bg_q;
  assign cmd_err    = err_q;

endmodule

// File: tb/tb_cmd_decoder.sv
// Bench for cmd_decoder: a queue models the shared command register and a
// command-level reference model predicts writes, colours, address and errors.
module tb_cmd_decoder;

  logic        clk = 1'b0;
  logic        nrst = 1'b1;
  logic        lb_wr;
  logic [7:0]  lb_wr_addr;
  logic [15:0] lb_wr_data;
  logic [11:0] fg_color;
  logic [11:0] bg_color;
  logic        cmd_err;

  always #5 clk = ~clk;

  cmd_decoder_if bus ();

  cmd_decoder dut (
    .clk        (clk),
    .nrst       (nrst),
    .bus        (bus.slave),
    .lb_wr      (lb_wr),
    .lb_wr_addr (lb_wr_addr),
    .lb_wr_data (lb_wr_data),
    .fg_color   (fg_color),
    .bg_color   (bg_color),
    .cmd_err    (cmd_err)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0]  shreg[$];
  logic [23:0] obs_wr[$];
  int          wr_cyc[$];
  int          cyc = 0;
  int          rd_cnt, consec_rd, rd_in_wr, err_cnt;
  bit          prev_rd;

  logic [7:0]  m_addr;
  logic [11:0] m_fg, m_bg;
  int          m_err, m_bytes;
  logic [23:0] m_wr[$];

  // Shared register model and output monitor, all at the falling edge.
  initial begin
    bus.has_data = 1'b0;
    bus.rd_data  = 8'h00;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.rd) begin
        rd_cnt++;
        if (prev_rd) consec_rd++;
        if (lb_wr) rd_in_wr++;
        if (shreg.size() != 0) void'(shreg.pop_front());
      end
      prev_rd = bus.rd;
      if (lb_wr) begin
        obs_wr.push_back({lb_wr_addr, lb_wr_data});
        wr_cyc.push_back(cyc);
      end
      if (cmd_err) err_cnt++;
      bus.has_data = (shreg.size() != 0);
      bus.rd_data  = (shreg.size() != 0) ? shreg[0] : 8'h00;
    end
  end

  task automatic clear_obs();
    obs_wr.delete();
    wr_cyc.delete();
    rd_cnt = 0; consec_rd = 0; rd_in_wr = 0; err_cnt = 0; prev_rd = 1'b0;
  endtask

  task automatic model_reset();
    m_addr = 8'h00; m_fg = 12'hFF0; m_bg = 12'h208; m_err = 0; m_bytes = 0;
    m_wr.delete();
  endtask

  // Push one command and apply its documented effect to the model.
  task automatic send(input logic [7:0] op, input logic [7:0] lo, input logic [7:0] hi);
    shreg.push_back(op);
    m_bytes++;
    if (op >= 8'd1 && op <= 8'd5) begin
      shreg.push_back(lo);
      m_bytes++;
      if (op != 8'd1) begin
        shreg.push_back(hi);
        m_bytes++;
      end
    end
    case (op)
      8'd1: m_addr = lo;
      8'd2: begin m_wr.push_back({m_addr, hi, lo}); m_addr = m_addr + 8'd1; end
      8'd3: m_fg = {lo, hi[3:0]};
      8'd4: m_bg = {lo, hi[3:0]};
      8'd5: begin
        for (int i = 0; i < 256; i++) m_wr.push_back({i[7:0], hi, lo});
        m_addr = 8'h00;
      end
      default: m_err++;
    endcase
  endtask

  task automatic do_reset();
    @(negedge clk);
    nrst = 1'b0;
    shreg.delete();
    @(negedge clk);
    @(negedge clk);
    clear_obs();
    model_reset();
    nrst = 1'b1;
  endtask

  task automatic wait_idle(input int budget);
    int quiet = 0;
    int n = 0;
    while (quiet < 8 && n < budget) begin
      @(negedge clk);
      n++;
      if (shreg.size() == 0 && !lb_wr && !bus.rd) quiet++;
      else quiet = 0;
    end
    total++;
    if (quiet < 8) begin
      bad++;
      $display("FAIL idle_timeout: quiet=%0d required=8 after %0d cycles", quiet, n);
    end
  endtask

  function automatic int wr_mism();
    int m = 0;
    for (int i = 0; i < obs_wr.size() && i < m_wr.size(); i++)
      if (obs_wr[i] !== m_wr[i]) m++;
    if (obs_wr.size() != m_wr.size()) m++;
    return m;
  endfunction

  task automatic test_reset();
    #1 nrst = 1'b0;
    #1;
    total++;
    if ({bus.rd, lb_wr, lb_wr_addr, lb_wr_data, cmd_err} !== 27'd0) begin
      bad++;
      $display("FAIL reset_zero: got rd=%b wr=%b addr=%h data=%h err=%b want all 0",
               bus.rd, lb_wr, lb_wr_addr, lb_wr_data, cmd_err);
    end
    total++;
    if (fg_color !== 12'hFF0 || bg_color !== 12'h208) begin
      bad++;
      $display("FAIL reset_colors: got fg=%h bg=%h want FF0 208", fg_color, bg_color);
    end
    shreg.push_back(8'h07);
    @(negedge clk);
    @(negedge clk);
    clear_obs();
    model_reset();
    nrst = 1'b1;
    @(negedge clk);
    total++;
    if (bus.rd !== 1'b0) begin
      bad++;
      $display("FAIL early_rd: rd=%b after first edge, want 0", bus.rd);
    end
    wait_idle(200);
    total++;
    if (rd_cnt != 1 || err_cnt != 1) begin
      bad++;
      $display("FAIL first_byte: rd_cnt=%0d err_cnt=%0d want 1 1", rd_cnt, err_cnt);
    end
  endtask

  task automatic test_write();
    do_reset();
    send(8'h02, 8'h34, 8'h12);
    wait_idle(200);
    total++;
    if (obs_wr.size() != 1 || obs_wr[0] !== 24'h00_1234) begin
      bad++;
      $display("FAIL write_word: n=%0d first=%h want 1 001234", obs_wr.size(),
               obs_wr.size() ? obs_wr[0] : 24'h0);
    end
    total++;
    if (lb_wr_addr !== 8'h01) begin
      bad++;
      $display("FAIL write_addr_inc: addr=%h want 01", lb_wr_addr);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    send(8'h01, 8'hFF, 8'h00);
    send(8'h02, 8'hAA, 8'h55);
    send(8'h02, 8'hAA, 8'h55);
    wait_idle(200);
    total++;
    if (obs_wr.size() != 2 || obs_wr[0] !== 24'hFF_55AA || obs_wr[1] !== 24'h00_55AA) begin
      bad++;
      $display("FAIL addr_wrap: n=%0d w0=%h w1=%h want 2 FF55AA 0055AA", obs_wr.size(),
               obs_wr.size() > 0 ? obs_wr[0] : 24'h0, obs_wr.size() > 1 ? obs_wr[1] : 24'h0);
    end
    total++;
    if (lb_wr_addr !== 8'h01) begin
      bad++;
      $display("FAIL wrap_final_addr: addr=%h want 01", lb_wr_addr);
    end
  endtask

  task automatic test_color();
    do_reset();
    send(8'h03, 8'h5A, 8'h0C);
    send(8'h04, 8'h00, 8'hF7);
    wait_idle(200);
    total++;
    if (fg_color !== 12'h5AC || bg_color !== 12'h007) begin
      bad++;
      $display("FAIL colors: fg=%h bg=%h want 5AC 007", fg_color, bg_color);
    end
    total++;
    if (obs_wr.size() != 0) begin
      bad++;
      $display("FAIL color_no_wr: writes=%0d want 0", obs_wr.size());
    end
  endtask

  task automatic test_fill();
    int n = 0;
    int gaps = 0;
    int bad_w = 0;
    do_reset();
    send(8'h05, 8'h00, 8'h80);
    send(8'h02, 8'h01, 8'h00);
    while (obs_wr.size() < 256 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    total++;
    if (lb_wr !== 1'b0 || lb_wr_addr !== 8'h00) begin
      bad++;
      $display("FAIL fill_end: wr=%b addr=%h want 0 00", lb_wr, lb_wr_addr);
    end
    wait_idle(500);
    for (int i = 0; i < 256 && i < obs_wr.size(); i++) begin
      if (obs_wr[i] !== {i[7:0], 16'h8000}) bad_w++;
      if (i > 0 && wr_cyc[i] != wr_cyc[i-1] + 1) gaps++;
    end
    total++;
    if (obs_wr.size() != 257 || bad_w != 0 || gaps != 0) begin
      bad++;
      $display("FAIL fill_writes: n=%0d bad_words=%0d gaps=%0d want 257 0 0",
               obs_wr.size(), bad_w, gaps);
    end
    total++;
    if (obs_wr.size() != 257 || obs_wr[256] !== 24'h00_0001 || rd_in_wr != 0 || rd_cnt != 6) begin
      bad++;
      $display("FAIL fill_queued: last=%h rd_in_wr=%0d rd_cnt=%0d want 000001 0 6",
               obs_wr.size() ? obs_wr[obs_wr.size()-1] : 24'h0, rd_in_wr, rd_cnt);
    end
  endtask

  task automatic test_err();
    do_reset();
    send(8'h07, 8'h00, 8'h00);
    send(8'h02, 8'h01, 8'h00);
    wait_idle(200);
    total++;
    if (err_cnt != 1 || rd_cnt != 4) begin
      bad++;
      $display("FAIL unknown_op: err_cycles=%0d rd_cnt=%0d want 1 4", err_cnt, rd_cnt);
    end
    total++;
    if (obs_wr.size() != 1 || obs_wr[0] !== 24'h00_0001 || fg_color !== 12'hFF0) begin
      bad++;
      $display("FAIL after_err: n=%0d w0=%h fg=%h want 1 000001 FF0", obs_wr.size(),
               obs_wr.size() ? obs_wr[0] : 24'h0, fg_color);
    end
  endtask

  task automatic test_midreset();
    int n = 0;
    do_reset();
    send(8'h02, 8'hCD, 8'hAB);
    send(8'h03, 8'h12, 8'h03);
    shreg.push_back(8'h02);
    shreg.push_back(8'h11);
    while (rd_cnt < 8 && n < 300) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (rd_cnt < 8) begin
      bad++;
      $display("FAIL midcmd_timeout: rd_cnt=%0d want 8", rd_cnt);
    end
    @(negedge clk);
    @(negedge clk);
    #2 nrst = 1'b0;
    #1;
    total++;
    if (lb_wr_addr !== 8'h00 || lb_wr_data !== 16'h0000 || fg_color !== 12'hFF0 ||
        bg_color !== 12'h208 || lb_wr !== 1'b0 || bus.rd !== 1'b0 || cmd_err !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: addr=%h data=%h fg=%h bg=%h wr=%b rd=%b err=%b want 00 0000 FF0 208 0 0 0",
               lb_wr_addr, lb_wr_data, fg_color, bg_color, lb_wr, bus.rd, cmd_err);
    end
    shreg.delete();
    @(negedge clk);
    @(negedge clk);
    clear_obs();
    model_reset();
    nrst = 1'b1;
    send(8'h02, 8'h22, 8'h33);
    wait_idle(200);
    total++;
    if (obs_wr.size() != 1 || obs_wr[0] !== 24'h00_3322) begin
      bad++;
      $display("FAIL post_reset_write: n=%0d w0=%h want 1 003322", obs_wr.size(),
               obs_wr.size() ? obs_wr[0] : 24'h0);
    end
  endtask

  task automatic test_back_to_back();
    int off = 0;
    do_reset();
    for (int i = 0; i < 4; i++)
      send(8'h02, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    wait_idle(300);
    for (int i = 1; i < wr_cyc.size(); i++)
      if (wr_cyc[i] - wr_cyc[i-1] != 6) off++;
    total++;
    if (wr_cyc.size() != 4 || off != 0) begin
      bad++;
      $display("FAIL throughput: writes=%0d off_spacing=%0d want 4 0", wr_cyc.size(), off);
    end
    total++;
    if (wr_mism() != 0) begin
      bad++;
      $display("FAIL b2b_data: mismatches=%0d want 0", wr_mism());
    end
  endtask

  task automatic test_random();
    int fills = 0;
    logic [7:0] op;
    do_reset();
    for (int c = 0; c < 60; c++) begin
      int r = $urandom_range(0, 99);
      if (r < 10)      op = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(6, 255));
      else if (r < 25) op = 8'h01;
      else if (r < 60) op = 8'h02;
      else if (r < 72) op = 8'h03;
      else if (r < 84) op = 8'h04;
      else if (fills < 2) begin op = 8'h05; fills++; end
      else op = 8'h02;
      send(op, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      repeat ($urandom_range(0, 8)) @(negedge clk);
    end
    wait_idle(5000);
    total++;
    if (wr_mism() != 0) begin
      bad++;
      $display("FAIL rand_writes: n=%0d want %0d mismatches=%0d", obs_wr.size(), m_wr.size(), wr_mism());
    end
    total++;
    if (fg_color !== m_fg || bg_color !== m_bg || lb_wr_addr !== m_addr) begin
      bad++;
      $display("FAIL rand_state: fg=%h bg=%h addr=%h want %h %h %h",
               fg_color, bg_color, lb_wr_addr, m_fg, m_bg, m_addr);
    end
    total++;
    if (err_cnt != m_err || rd_cnt != m_bytes || consec_rd != 0 || rd_in_wr != 0) begin
      bad++;
      $display("FAIL rand_handshake: err=%0d rd=%0d consec=%0d rd_in_wr=%0d want %0d %0d 0 0",
               err_cnt, rd_cnt, consec_rd, rd_in_wr, m_err, m_bytes);
    end
  endtask

  initial begin
    clear_obs();
    model_reset();
    test_reset();
    test_write();
    test_wrap();
    test_color();
    test_fill();
    test_err();
    test_midreset();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
